// File: rtl/tetrimino_driver_p.sv
// Active-piece controller: spawns a tetrimino, applies gravity, shifts and
// rotations against the fixed field, and hands the landed piece to the field
// owner through a valid/ready lock handshake.
module tetrimino_driver_p #(
  parameter int unsigned COLS      = 8,
  parameter int unsigned ROWS      = 8,
  parameter int unsigned SPAWN_COL = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 gravity_tick,
  input  logic                 left,
  input  logic                 right,
  input  logic                 down,
  input  logic                 rot_cw,
  input  logic                 rot_ccw,
  input  logic [2:0]           next_type,
  input  logic [ROWS*COLS-1:0] fixed_in,
  input  logic                 lock_ready,
  output logic [ROWS*COLS-1:0] active_out,
  output logic                 display_en,
  output logic                 lock_valid,
  output logic                 game_over,
  output logic [2:0]           piece_type,
  output logic [15:0]          piece_count
);

  localparam int unsigned NCELL  = ROWS * COLS;
  localparam int unsigned DIMMAX = (ROWS > COLS) ? ROWS : COLS;
  localparam int unsigned OW     = $clog2(DIMMAX) + 2;
  localparam int unsigned IW     = $clog2(NCELL) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SPAWN = 3'd1;
  localparam logic [2:0] S_FALL  = 3'd2;
  localparam logic [2:0] S_LOCK  = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam logic [2:0] T_I = 3'd0;
  localparam logic [2:0] T_J = 3'd1;
  localparam logic [2:0] T_L = 3'd2;
  localparam logic [2:0] T_O = 3'd3;
  localparam logic [2:0] T_S = 3'd4;
  localparam logic [2:0] T_T = 3'd5;
  localparam logic [2:0] T_Z = 3'd6;

  // 3-bit two's-complement offset constants
  localparam logic [2:0] M1 = 3'b111;
  localparam logic [2:0] Z0 = 3'b000;
  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] P2 = 3'b010;

  // Unrotated offset {dx,dy} of block idx for piece type t
  function automatic logic [5:0] base_off(input logic [2:0] t, input logic [1:0] idx);
    logic [5:0] r;
    r = {Z0, Z0};
    case (t)
      T_J: case (idx)
             2'd0:    r = {M1, Z0};
             2'd1:    r = {Z0, Z0};
             2'd2:    r = {P1, Z0};
             default: r = {P1, P1};
           endcase
      T_L: case (idx)
             2'd0:    r = {M1, Z0};
             2'd1:    r = {Z0, Z0};
             2'd2:    r = {P1, Z0};
             default: r = {M1, P1};
           endcase
      T_O: case (idx)
             2'd0:    r = {Z0, P1};
             2'd1:    r = {Z0, Z0};
             2'd2:    r = {P1, Z0};
             default: r = {P1, P1};
           endcase
      T_S: case (idx)
             2'd0:    r = {M1, P1};
             2'd1:    r = {Z0, Z0};
             2'd2:    r = {P1, Z0};
             default: r = {Z0, P1};
           endcase
      T_T: case (idx)
             2'd0:    r = {M1, Z0};
             2'd1:    r = {Z0, Z0};
             2'd2:    r = {P1, Z0};
             default: r = {Z0, P1};
           endcase
      T_Z: case (idx)
             2'd0:    r = {M1, Z0};
             2'd1:    r = {Z0, Z0};
             2'd2:    r = {Z0, P1};
             default: r = {P1, P1};
           endcase
      default: case (idx)
             2'd0:    r = {M1, Z0};
             2'd1:    r = {Z0, Z0};
             2'd2:    r = {P1, Z0};
             default: r = {P2, Z0};
           endcase
    endcase
    return r;
  endfunction

  // Apply rot quarter turns clockwise: one turn maps (dx,dy) -> (-dy,dx)
  function automatic logic [5:0] rot_off(input logic [5:0] o, input logic [1:0] rot);
    logic [2:0] dx;
    logic [2:0] dy;
    logic [5:0] r;
    dx = o[5:3];
    dy = o[2:0];
    case (rot)
      2'd0:    r = {dx, dy};
      2'd1:    r = {-dy, dx};
      2'd2:    r = {-dx, -dy};
      default: r = {dy, -dx};
    endcase
    return r;
  endfunction

  logic [2:0]          state_q, state_d;
  logic signed [OW-1:0] col_q, col_d;
  logic signed [OW-1:0] row_q, row_d;
  logic [1:0]          rot_q, rot_d;
  logic [2:0]          type_q, type_d;
  logic [15:0]         count_q, count_d;
  logic [NCELL-1:0]    active_q, active_d;
  logic                disp_q, lv_q, go_q;

  logic                 act_down, act_any;
  logic [2:0]           cand_type;
  logic signed [OW-1:0] cand_col, cand_row;
  logic [1:0]           cand_rot;
  logic [NCELL-1:0]     cand_mask;
  logic                 cand_in;
  logic                 cand_legal;
  logic [5:0]           off;
  logic signed [OW-1:0] cx, cy;

  // Pick the single candidate placement for this cycle and test it against the field
  always_comb begin
    act_down  = gravity_tick | down;
    act_any   = act_down | rot_cw | rot_ccw | left | right;
    cand_type = type_q;
    cand_col  = col_q;
    cand_row  = row_q;
    cand_rot  = rot_q;
    if (state_q == S_SPAWN) begin
      cand_type = (next_type == 3'd7) ? T_I : next_type;
      cand_col  = OW'(SPAWN_COL);
      cand_row  = '0;
      cand_rot  = '0;
    end else if (act_down) begin
      cand_row = row_q + OW'(1);
    end else if (rot_cw) begin
      if (type_q != T_O) cand_rot = rot_q + 2'd1;
    end else if (rot_ccw) begin
      if (type_q != T_O) cand_rot = rot_q - 2'd1;
    end else if (left) begin
      cand_col = col_q - OW'(1);
    end else if (right) begin
      cand_col = col_q + OW'(1);
    end

    cand_mask = '0;
    cand_in   = 1'b1;
    off       = '0;
    cx        = '0;
    cy        = '0;
    for (int i = 0; i < 4; i++) begin
      off = rot_off(base_off(cand_type, 2'(i)), cand_rot);
      cx  = cand_col + {{(OW-3){off[5]}}, off[5:3]};
      cy  = cand_row + {{(OW-3){off[2]}}, off[2:0]};
      if (cx[OW-1] || cy[OW-1] || (cx >= OW'(COLS)) || (cy >= OW'(ROWS)))
        cand_in = 1'b0;
      else
        cand_mask = cand_mask | (NCELL'(1) << (IW'(cy) * IW'(COLS) + IW'(cx)));
    end
    cand_legal = cand_in && ((cand_mask & fixed_in) == '0);
  end

  // Next-state and next-piece logic
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    rot_d    = rot_q;
    type_d   = type_q;
    count_d  = count_q;
    active_d = active_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SPAWN;
      end
      S_SPAWN: begin
        type_d = cand_type;
        col_d  = cand_col;
        row_d  = cand_row;
        rot_d  = cand_rot;
        if (cand_legal) begin
          state_d  = S_FALL;
          active_d = cand_mask;
        end else begin
          state_d = S_OVER;
        end
      end
      S_FALL: begin
        if (act_any) begin
          if (cand_legal) begin
            col_d    = cand_col;
            row_d    = cand_row;
            rot_d    = cand_rot;
            active_d = cand_mask;
          end else if (act_down) begin
            state_d = S_LOCK;
          end
        end
      end
      S_LOCK: begin
        if (lock_ready) begin
          count_d  = count_q + 16'd1;
          state_d  = S_SPAWN;
          active_d = '0;
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if ((state_d == S_OVER) || (state_d == S_IDLE)) active_d = '0;
  end

  // State, piece and registered-output update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      col_q    <= OW'(SPAWN_COL);
      row_q    <= '0;
      rot_q    <= '0;
      type_q   <= '0;
      count_q  <= '0;
      active_q <= '0;
      disp_q   <= 1'b0;
      lv_q     <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      rot_q    <= rot_d;
      type_q   <= type_d;
      count_q  <= count_d;
      active_q <= active_d;
      disp_q   <= (state_d == S_SPAWN) || (state_d == S_FALL) || (state_d == S_LOCK);
      lv_q     <= (state_d == S_LOCK);
      go_q     <= (state_d == S_OVER);
    end
  end

  assign active_out  = active_q;
  assign display_en  = disp_q;
  assign lock_valid  = lv_q;
  assign game_over   = go_q;
  assign piece_type  = type_q;
  assign piece_count = count_q;

endmodule
